// File: rtl/fifo_ring_buffer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : fifo_ring_buffer                                             |
// | Description : Synchronous FIFO on a circular buffer of arbitrary depth,    |
// |               with almost-full/almost-empty thresholds, sticky overflow/   |
// |               underflow flags and synchronous flush.                       |
// |               Optional macro FIFO_FWFT_EN selects first-word fall-through  |
// |               read; default build is a registered 1-cycle read.            |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module fifo_ring_buffer #(
  parameter int BUFFER_WIDTH = 23,
  parameter int BUFFER_DEPTH = 23,
  parameter int AF_LEVEL     = BUFFER_DEPTH - 2,
  parameter int AE_LEVEL     = 2,
  localparam int c_CW        = $clog2(BUFFER_DEPTH + 1)
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_push,
  input  logic                    i_pull,
  input  logic                    i_flush,
  input  logic                    i_clear_err,
  input  logic [BUFFER_WIDTH-1:0] i_tail,
  output logic [BUFFER_WIDTH-1:0] o_head,
  output logic [c_CW-1:0]         o_counter,
  output logic                    o_full,
  output logic                    o_empty,
  output logic                    o_almost_full,
  output logic                    o_almost_empty,
  output logic                    o_overflow,
  output logic                    o_underflow
);

  localparam int c_PW = (BUFFER_DEPTH > 2) ? $clog2(BUFFER_DEPTH) : 1;
  localparam logic [c_PW-1:0] c_LAST_PTR = c_PW'(BUFFER_DEPTH - 1);
  localparam logic [c_CW-1:0] c_DEPTH    = c_CW'(BUFFER_DEPTH);
  localparam logic [c_CW-1:0] c_AF       = c_CW'(AF_LEVEL);
  localparam logic [c_CW-1:0] c_AE       = c_CW'(AE_LEVEL);

  logic [BUFFER_WIDTH-1:0] r_mem [BUFFER_DEPTH];
  logic [c_PW-1:0]         r_wr_ptr;
  logic [c_PW-1:0]         r_rd_ptr;
  logic [c_CW-1:0]         r_counter;
  logic                    r_overflow;
  logic                    r_underflow;

  logic w_full;
  logic w_empty;
  logic w_push_ok;
  logic w_pull_ok;
  logic w_ovf_set;
  logic w_unf_set;

  // Explicit wrap at the last entry so any depth works, not only powers of 2.
  function automatic logic [c_PW-1:0] f_next(input logic [c_PW-1:0] p);
    return (p == c_LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  assign w_full  = (r_counter == c_DEPTH);
  assign w_empty = (r_counter == '0);

  // Flush blocks both transfers and suppresses error detection on that edge.
  assign w_push_ok = i_push & (~w_full | i_pull) & ~i_flush;
  assign w_pull_ok = i_pull & ~w_empty & ~i_flush;
  assign w_ovf_set = i_push & ~w_push_ok & ~i_flush;
  assign w_unf_set = i_pull & ~w_pull_ok & ~i_flush;

  // Storage array: written on accepted push, never reset.
  always_ff @(posedge i_clk) begin
    if (w_push_ok) begin
      r_mem[r_wr_ptr] <= i_tail;
    end
  end

  // Pointers and occupancy counter.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_counter <= '0;
    end else if (i_flush) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_counter <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= f_next(r_wr_ptr);
      if (w_pull_ok) r_rd_ptr <= f_next(r_rd_ptr);
      case ({w_push_ok, w_pull_ok})
        2'b10:   r_counter <= r_counter + 1'b1;
        2'b01:   r_counter <= r_counter - 1'b1;
        default: r_counter <= r_counter;
      endcase
    end
  end

  // Sticky error flags; a new error on the same edge beats clear_err.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_ovf_set)        r_overflow  <= 1'b1;
      else if (i_clear_err) r_overflow  <= 1'b0;
      if (w_unf_set)        r_underflow <= 1'b1;
      else if (i_clear_err) r_underflow <= 1'b0;
    end
  end

`ifdef FIFO_FWFT_EN
  // Fall-through read: the oldest word is visible whenever the FIFO holds data.
  always_comb begin
    o_head = '0;
    if (!w_empty) o_head = r_mem[r_rd_ptr];
  end
`else
  logic [BUFFER_WIDTH-1:0] r_head;

  // Registered read: head updates one cycle after an accepted pull, else holds.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_head <= '0;
    end else if (w_pull_ok) begin
      r_head <= r_mem[r_rd_ptr];
    end
  end

  assign o_head = r_head;
`endif

  assign o_counter      = r_counter;
  assign o_full         = w_full;
  assign o_empty        = w_empty;
  assign o_almost_full  = (r_counter >= c_AF);
  assign o_almost_empty = (r_counter <= c_AE);
  assign o_overflow     = r_overflow;
  assign o_underflow    = r_underflow;

endmodule
`default_nettype wire

// File: tb/tb_fifo_ring_buffer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_fifo_ring_buffer                                          |
// | Description : Directed bench for fifo_ring_buffer with a queue scoreboard. |
// |               Honours FIFO_FWFT_EN for the head expectation.               |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_fifo_ring_buffer;

  localparam int c_W  = 23;
  localparam int c_D  = 23;
  localparam int c_AF = c_D - 2;
  localparam int c_AE = 2;
  localparam int c_CW = $clog2(c_D + 1);

  logic           r_clk = 1'b0;
  logic           r_rst_n;
  logic           r_push, r_pull, r_flush, r_clear_err;
  logic [c_W-1:0] r_tail;
  logic [c_W-1:0] w_head;
  logic [c_CW-1:0] w_counter;
  logic w_full, w_empty, w_af, w_ae, w_ovf, w_unf;

  int n_cmp = 0;
  int n_err = 0;

  // Scoreboard: words expected to come out, oldest first.
  logic [c_W-1:0] q_exp[$];
  logic [c_W-1:0] m_head;
  logic           m_ovf, m_unf;

  fifo_ring_buffer #(
    .BUFFER_WIDTH(c_W), .BUFFER_DEPTH(c_D), .AF_LEVEL(c_AF), .AE_LEVEL(c_AE)
  ) u_dut (
    .i_clk(r_clk), .i_rst_n(r_rst_n), .i_push(r_push), .i_pull(r_pull),
    .i_flush(r_flush), .i_clear_err(r_clear_err), .i_tail(r_tail),
    .o_head(w_head), .o_counter(w_counter), .o_full(w_full), .o_empty(w_empty),
    .o_almost_full(w_af), .o_almost_empty(w_ae),
    .o_overflow(w_ovf), .o_underflow(w_unf)
  );

  always #5 r_clk = ~r_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Compare every visible output against the scoreboard model.
  task automatic chk_all(input string tag);
    int sz;
    logic [c_W-1:0] eh;
    sz = q_exp.size();
`ifdef FIFO_FWFT_EN
    eh = (sz != 0) ? q_exp[0] : '0;
`else
    eh = m_head;
`endif
    chk({tag, ".counter"}, 32'(w_counter), 32'(sz));
    chk({tag, ".empty"},   32'(w_empty),   32'(sz == 0));
    chk({tag, ".full"},    32'(w_full),    32'(sz == c_D));
    chk({tag, ".afull"},   32'(w_af),      32'(sz >= c_AF));
    chk({tag, ".aempty"},  32'(w_ae),      32'(sz <= c_AE));
    chk({tag, ".ovf"},     32'(w_ovf),     32'(m_ovf));
    chk({tag, ".unf"},     32'(w_unf),     32'(m_unf));
    chk({tag, ".head"},    32'(w_head),    32'(eh));
  endtask

  task automatic model_reset();
    q_exp.delete();
    m_head = '0;
    m_ovf  = 1'b0;
    m_unf  = 1'b0;
  endtask

  // One clock of stimulus; inputs change 1 time unit after the rising edge.
  task automatic step(input string tag, input bit p, input bit r, input bit f,
                      input bit c, input logic [c_W-1:0] d);
    bit full_m, empty_m, pok, rok;
    full_m  = (q_exp.size() == c_D);
    empty_m = (q_exp.size() == 0);
    pok     = p && !f && (!full_m || r);
    rok     = r && !f && !empty_m;
    r_push = p; r_pull = r; r_flush = f; r_clear_err = c; r_tail = d;
    @(posedge r_clk);
    #1;
    r_push = 0; r_pull = 0; r_flush = 0; r_clear_err = 0;
    if (p && !pok && !f) m_ovf = 1'b1; else if (c) m_ovf = 1'b0;
    if (r && !rok && !f) m_unf = 1'b1; else if (c) m_unf = 1'b0;
    if (f) begin
      q_exp.delete();
    end else begin
      if (rok) m_head = q_exp.pop_front();
      if (pok) q_exp.push_back(d);
    end
    chk_all(tag);
  endtask

  initial begin
    r_rst_n = 1'b0;
    r_push = 0; r_pull = 0; r_flush = 0; r_clear_err = 0; r_tail = '0;
    model_reset();
    repeat (3) @(posedge r_clk);
    #1;
    chk_all("reset");
    r_rst_n = 1'b1;
    step("idle", 0, 0, 0, 0, '0);

    // Fill and drain three times; pointers wrap from 22 back to 0.
    for (int rnd = 0; rnd < 3; rnd++) begin
      for (int i = 1; i <= c_D; i++) step("fill", 1, 0, 0, 0, c_W'(i));
      for (int i = 1; i <= c_D; i++) step("drain", 0, 1, 0, 0, '0);
    end

    // Overflow on full, data 0x18 must never come out; underflow on empty.
    for (int i = 1; i <= c_D; i++) step("ofill", 1, 0, 0, 0, c_W'(i));
    step("ovf_push", 1, 0, 0, 0, 23'h18);
    for (int i = 1; i <= c_D; i++) step("odrain", 0, 1, 0, 0, '0);
    step("unf_pull", 0, 1, 0, 0, '0);
    step("clr_err", 0, 0, 0, 1, '0);

    // Full plus simultaneous push and pull: no overflow, order preserved.
    for (int i = 0; i < c_D; i++) step("ffill", 1, 0, 0, 0, c_W'(12'h100 + i));
    step("full_pp", 1, 1, 0, 0, 23'h200);
    for (int i = 0; i < c_D; i++) step("fdrain", 0, 1, 0, 0, '0);

    // Empty plus simultaneous push and pull: push only, underflow set.
    step("empty_pp", 1, 1, 0, 0, 23'h55);
    step("epull", 0, 1, 0, 0, '0);
    // New error on the same edge as clear_err keeps the flag set.
    step("clr_vs_err", 0, 1, 0, 1, '0);
    step("clr_err2", 0, 0, 0, 1, '0);

    // Flush with push asserted: empties, no error, head unchanged.
    for (int i = 0; i < 10; i++) step("lfill", 1, 0, 0, 0, c_W'(12'h300 + i));
    step("flush", 1, 1, 1, 0, 23'h3FF);
    step("post_flush", 1, 0, 0, 0, 23'h0AB);
    step("pf_pull", 0, 1, 0, 0, '0);

    // Random mix to wrap pointers at arbitrary positions.
    for (int i = 0; i < 300; i++)
      step("rand", bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)),
           ($urandom_range(0, 49) == 0), ($urandom_range(0, 9) == 0),
           c_W'($urandom));

    // Asynchronous reset mid-cycle with 5 words held.
    step("pre_rst_flush", 0, 0, 1, 1, '0);
    for (int i = 0; i < 5; i++) step("rfill", 1, 0, 0, 0, c_W'(12'h400 + i));
    #3;
    r_rst_n = 1'b0;
    #1;
    model_reset();
    chk_all("async_rst");
    #2;
    r_rst_n = 1'b1;
    step("after_rst", 0, 0, 0, 0, '0);

    // Single word: fall-through shows it without a pull in FWFT builds.
    step("aa_push", 1, 0, 0, 0, 23'h0000AA);
    step("aa_idle", 0, 0, 0, 0, '0);
    step("aa_pull", 0, 1, 0, 0, '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
